// File: rtl/usb_autodetect_ctrl_pkg.sv
// Shared speed codes and sequencer state encoding for the USB speed autodetect controller.
package usb_autodetect_ctrl_pkg;

    localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
    localparam logic [1:0] USB_SPEED_LS   = 2'd1;
    localparam logic [1:0] USB_SPEED_FS   = 2'd2;
    localparam logic [1:0] USB_SPEED_HS   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRestart,
        StWait,
        StConfirm,
        StDone,
        StFail
    } state_e;

endpackage

// File: rtl/usb_autodetect_ctrl_speed_sync.sv
// Two-flop synchronizer for the detector speed plus candidate capture and stability counting.
module usb_autodetect_ctrl_speed_sync
    import usb_autodetect_ctrl_pkg::*;
#(
    parameter int unsigned pSTABLE_CYCLES = 4
) (
    input  logic       cwusb_clk,
    input  logic       reset_i,
    input  logic [1:0] I_speed,
    input  logic       I_capture,
    input  logic       I_advance,
    output logic [1:0] O_sync_speed,
    output logic [1:0] O_candidate,
    output logic       O_match,
    output logic       O_stable
);

    localparam int unsigned CW = $clog2(pSTABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(pSTABLE_CYCLES - 1);

    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic [1:0]    r_candidate;
    logic [CW-1:0] r_count;

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            r_meta      <= USB_SPEED_AUTO;
            r_sync      <= USB_SPEED_AUTO;
            r_candidate <= USB_SPEED_AUTO;
            r_count     <= '0;
        end else begin
            r_meta <= I_speed;
            r_sync <= r_meta;
            if (I_capture) begin
                r_candidate <= r_sync;
                r_count     <= CW'(1);
            end else if (I_advance) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign O_sync_speed = r_sync;
    assign O_candidate  = r_candidate;
    assign O_match      = (r_sync == r_candidate);
    // Stable when this matching cycle brings the run up to pSTABLE_CYCLES.
    assign O_stable     = O_match && (r_count >= STABLE_LAST);

endmodule

// File: rtl/usb_autodetect_ctrl.sv
// Restart/confirm/retry sequencer around the usb_autodetect speed detector.
module usb_autodetect_ctrl
    import usb_autodetect_ctrl_pkg::*;
#(
    parameter int unsigned pCOUNTER_WIDTH  = 24,
    parameter int unsigned pTIMEOUT_WIDTH  = 32,
    parameter int unsigned pRESTART_CYCLES = 10,
    parameter int unsigned pSTABLE_CYCLES  = 4
) (
    input  logic                      cwusb_clk,
    input  logic                      reset_i,
    input  logic                      I_start,
    input  logic                      I_abort,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
    input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
    input  logic [3:0]                I_max_attempts,
    input  logic [1:0]                I_speed,
    output logic                      O_restart,
    output logic [pCOUNTER_WIDTH-1:0] O_wait1,
    output logic [pCOUNTER_WIDTH-1:0] O_wait2,
    output logic                      O_busy,
    output logic                      O_done,
    output logic                      O_fail,
    output logic [1:0]                O_speed,
    output logic [3:0]                O_attempts
);

    localparam int unsigned RW = $clog2(pRESTART_CYCLES + 1);
    localparam logic [RW-1:0] RESTART_LAST = RW'(pRESTART_CYCLES - 1);

    state_e                    r_state;
    state_e                    w_state_next;
    logic [pCOUNTER_WIDTH-1:0] r_wait1;
    logic [pCOUNTER_WIDTH-1:0] r_wait2;
    logic [pTIMEOUT_WIDTH-1:0] r_timeout;
    logic [pTIMEOUT_WIDTH-1:0] r_tcnt;
    logic [3:0]                r_max;
    logic [3:0]                r_attempts;
    logic [RW-1:0]             r_rcnt;
    logic                      r_done;
    logic                      r_fail;
    logic [1:0]                r_speed;

    logic [1:0] w_sync;
    logic [1:0] w_candidate;
    logic       w_match;
    logic       w_stable;
    logic       w_capture;
    logic       w_advance;
    logic       w_launch;
    logic       w_retry;
    logic       w_accept;
    logic       w_give_up;
    logic       w_timeout_hit;
    logic [1:0] w_accept_speed;

    usb_autodetect_ctrl_speed_sync #(
        .pSTABLE_CYCLES (pSTABLE_CYCLES)
    ) u_speed_sync (
        .cwusb_clk    (cwusb_clk),
        .reset_i      (reset_i),
        .I_speed      (I_speed),
        .I_capture    (w_capture),
        .I_advance    (w_advance),
        .O_sync_speed (w_sync),
        .O_candidate  (w_candidate),
        .O_match      (w_match),
        .O_stable     (w_stable)
    );

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_capture      = 1'b0;
        w_advance      = 1'b0;
        w_launch       = 1'b0;
        w_retry        = 1'b0;
        w_accept       = 1'b0;
        w_give_up      = 1'b0;
        w_accept_speed = w_candidate;
        w_timeout_hit  = (r_timeout != '0) && (r_tcnt == r_timeout);
        if (I_abort) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone, StFail: begin
                    if (I_start) begin
                        w_launch     = 1'b1;
                        w_state_next = StRestart;
                    end
                end
                StRestart: begin
                    if (r_rcnt == RESTART_LAST) w_state_next = StWait;
                end
                StWait: begin
                    if (w_sync != USB_SPEED_AUTO && pSTABLE_CYCLES == 1) begin
                        w_accept       = 1'b1;
                        w_accept_speed = w_sync;
                    end else if (w_timeout_hit) begin
                        w_retry   = (r_attempts < r_max);
                        w_give_up = !(r_attempts < r_max);
                    end else if (w_sync != USB_SPEED_AUTO) begin
                        w_capture    = 1'b1;
                        w_state_next = StConfirm;
                    end
                end
                StConfirm: begin
                    // A completed stability run beats a timeout on the same cycle.
                    if (w_stable) begin
                        w_accept = 1'b1;
                    end else if (w_timeout_hit) begin
                        w_retry   = (r_attempts < r_max);
                        w_give_up = !(r_attempts < r_max);
                    end else if (!w_match) begin
                        w_state_next = StWait;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                default: w_state_next = StIdle;
            endcase
            if (w_accept)  w_state_next = StDone;
            if (w_retry)   w_state_next = StRestart;
            if (w_give_up) w_state_next = StFail;
        end
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            r_wait1    <= '0;
            r_wait2    <= '0;
            r_timeout  <= '0;
            r_max      <= 4'd1;
            r_attempts <= 4'd0;
            r_rcnt     <= '0;
            r_tcnt     <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_speed    <= USB_SPEED_AUTO;
        end else begin
            if (I_abort) begin
                r_done  <= 1'b0;
                r_fail  <= 1'b0;
                r_speed <= USB_SPEED_AUTO;
            end else begin
                if (w_launch) begin
                    r_wait1    <= I_wait1;
                    r_wait2    <= I_wait2;
                    r_timeout  <= I_timeout;
                    r_max      <= (I_max_attempts == 4'd0) ? 4'd1 : I_max_attempts;
                    r_attempts <= 4'd1;
                    r_done     <= 1'b0;
                    r_fail     <= 1'b0;
                    r_speed    <= USB_SPEED_AUTO;
                end
                if (w_retry) r_attempts <= r_attempts + 4'd1;
                if (w_accept) begin
                    r_done  <= 1'b1;
                    r_speed <= w_accept_speed;
                end
                if (w_give_up) begin
                    r_fail  <= 1'b1;
                    r_speed <= USB_SPEED_AUTO;
                end
            end
            r_rcnt <= (r_state == StRestart && w_state_next == StRestart) ?
                      r_rcnt + RW'(1) : '0;
            if (r_state == StRestart) begin
                r_tcnt <= '0;
            end else if ((r_state == StWait || r_state == StConfirm) && r_tcnt != '1) begin
                r_tcnt <= r_tcnt + pTIMEOUT_WIDTH'(1);
            end
        end
    end

    assign O_restart  = (r_state == StRestart);
    assign O_busy     = (r_state == StRestart) || (r_state == StWait) || (r_state == StConfirm);
    assign O_wait1    = r_wait1;
    assign O_wait2    = r_wait2;
    assign O_done     = r_done;
    assign O_fail     = r_fail;
    assign O_speed    = r_speed;
    assign O_attempts = r_attempts;

endmodule

// File: doc/usb_autodetect_ctrl.md
Name: usb_autodetect_ctrl

Overview:
Sequencer for the usb_autodetect speed detector; runs entirely in the cwusb_clk domain.
- On a start command it latches the wait thresholds, pulses the detector restart and watches the detector speed output.
- A detected speed is accepted only once it has been stable for a set time; an attempt that runs out of time is retried, up to a limit.
- Reports busy/done/fail, final speed and attempt count to the register block.

Parameters:
pCOUNTER_WIDTH, 24, width of the wait1/wait2 thresholds passed to the detector
pTIMEOUT_WIDTH, 32, width of the per-attempt timeout counter
pRESTART_CYCLES, 10, cycles O_restart is held high per attempt (>=1)
pSTABLE_CYCLES, 4, consecutive synchronized cycles a non-AUTO speed must hold before acceptance (>=1)

Ports:
cwusb_clk  in  1  sole clock
reset_i  in  1  reset, asynchronous, active-high
I_start  in  1  single-cycle start pulse
I_abort  in  1  single-cycle abort pulse
I_wait1  in  pCOUNTER_WIDTH  line-high threshold, latched at start
I_wait2  in  pCOUNTER_WIDTH  line-low threshold, latched at start
I_timeout  in  pTIMEOUT_WIDTH  cycles allowed per attempt; 0 = no timeout
I_max_attempts  in  4  attempt limit; 0 is treated as 1
I_speed  in  2  detector speed output (asynchronous to cwusb_clk)
O_restart  out  1  detector restart
O_wait1  out  pCOUNTER_WIDTH  latched threshold to detector
O_wait2  out  pCOUNTER_WIDTH  latched threshold to detector
O_busy  out  1  sequence in progress
O_done  out  1  speed accepted (level)
O_fail  out  1  attempts exhausted (level)
O_speed  out  2  accepted speed
O_attempts  out  4  attempts started in current/last sequence

Behaviour:
Reset values:
- O_restart, O_busy, O_done, O_fail = 0
- O_speed = USB_SPEED_AUTO
- O_wait1, O_wait2, O_attempts = 0
- state IDLE
I_speed path: passes through a 2-FF synchronizer; sync_speed is the second stage. Latency from I_speed change to sync_speed is 2 cycles.

State machine: IDLE, RESTART, WAIT, CONFIRM, DONE, FAIL.
- IDLE/DONE/FAIL + I_start -> RESTART next cycle:
  - latch I_wait1/I_wait2/I_timeout/I_max_attempts
  - attempts = 1; clear O_done, O_fail; O_speed = USB_SPEED_AUTO
- RESTART:
  - O_restart = 1 for exactly pRESTART_CYCLES cycles
  - timeout counter cleared
  - then -> WAIT, with O_restart = 0 from that cycle
- WAIT:
  - timeout counter increments every cycle
  - sync_speed != USB_SPEED_AUTO -> CONFIRM; capture candidate; stable count = 1
- CONFIRM:
  - sync_speed == candidate: stable count increments; on reaching pSTABLE_CYCLES -> DONE, O_speed = candidate, O_done = 1
  - sync_speed != candidate -> WAIT; timeout counter NOT cleared
  - timeout counter keeps incrementing
- Timeout, in WAIT or CONFIRM, when latched timeout != 0 and counter == latched timeout:
  - attempts < max_attempts -> RESTART, attempts += 1
  - otherwise -> FAIL, O_fail = 1, O_speed = USB_SPEED_AUTO
- DONE/FAIL hold their outputs until the next I_start or I_abort.
- O_busy = 1 in RESTART, WAIT, CONFIRM.

Boundary and simultaneous events:
- Stability completes in the same cycle as timeout -> success (DONE) wins.
- I_abort from any state -> IDLE next cycle:
  - O_restart = 0; O_done, O_fail cleared; O_speed = AUTO
  - O_attempts retained
- I_start and I_abort in the same cycle -> abort wins.
- I_start while busy -> ignored.
- Changes to I_wait*/I_timeout during a sequence have no effect until the next start.
- Reset mid-operation -> all reset values immediately (asynchronous).
- Timeout counter never wraps: latched timeout = 0 disables the counter compare; the counter saturates at all-ones.

Decomposition:
- USB_SPEED_AUTO/LS/FS/HS come from the shared defines.v.
- The state encoding constants go in the same shared include.
- Natural sub-module: usb_speed_sync (2-FF synchronizer plus stability check, outputs candidate and stable flag). The FSM and counters stay in the top.

Test Plan:
1. timeout=0, max=1. Start; drive I_speed=LS 30 cycles after restart falls -> O_restart high for 10 cycles; O_done=1 and O_speed=LS about 2+4 cycles later; O_attempts=1.
2. timeout=100, max=3, I_speed held AUTO -> exactly 3 restart pulses, O_fail=1 at cycle ~3*(10+100), O_speed=AUTO, O_attempts=3.
3. Glitch: I_speed=FS for 2 cycles, then AUTO, then HS held -> no DONE on FS; O_done with O_speed=HS.
4. Stability completes on the exact timeout cycle -> O_done=1, O_fail=0, only one restart pulse.
5. Abort during RESTART, then start+abort in the same cycle -> O_restart drops next cycle, state IDLE, O_busy=0, no new sequence.
6. Change I_wait1 mid-sequence from 32 to 64 -> O_wait1 stays 32 until the next I_start, then reads 64.
